// File: rtl/gate_test_sequencer_pkg.sv
// Shared definitions for the gate test sequencer: FSM state encoding,
// gate_y bit positions and the expected truth table for the four vectors.
package gate_test_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Bit positions inside gate_y / err_mask (ascending [0:6] range).
    localparam int unsigned Y_AND  = 0;
    localparam int unsigned Y_OR   = 1;
    localparam int unsigned Y_NOTA = 2;
    localparam int unsigned Y_NAND = 3;
    localparam int unsigned Y_NOR  = 4;
    localparam int unsigned Y_XOR  = 5;
    localparam int unsigned Y_XNOR = 6;

    localparam int unsigned NUM_GATES = 7;
    localparam int unsigned NUM_VECS  = 4;

    // Expected results indexed by vec = {gate_a, gate_b}.
    // Leftmost literal bit lands in index 0 (AND), rightmost in index 6 (XNOR).
    localparam logic [0:6] EXP_TABLE [0:3] = '{
        7'b0011101,  // a=0 b=0
        7'b0111010,  // a=0 b=1
        7'b0101010,  // a=1 b=0
        7'b1100001   // a=1 b=1
    };

endpackage

// File: rtl/gate_test_sequencer_ref_model.sv
// Combinational lookup of the expected gate block response for one vector.
module gate_ref_model
    import gate_test_sequencer_pkg::*;
(
    input  logic [1:0] vec_i,
    output logic [0:6] exp_o
);

    // Pure table lookup; vec_i always addresses a valid row.
    always_comb begin
        exp_o = EXP_TABLE[vec_i];
    end

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks the four {gate_a,gate_b} input combinations through an external
// gate block, holds each for HOLD_CYCLES, samples gate_y once per vector
// and accumulates a per-bit and per-vector mismatch record.
module gate_test_sequencer
    import gate_test_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       gate_a,
    output logic       gate_b,
    input  logic [0:6] gate_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [0:6] err_mask,
    output logic [3:0] fail_vec,
    output logic [2:0] fail_count
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_e     state_q;
    logic [1:0] vec_q;
    logic [3:0] hold_q;
    logic       gate_a_q;
    logic       gate_b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [0:6] err_mask_q;
    logic [3:0] fail_vec_q;
    logic [2:0] fail_count_q;

    logic [0:6] exp_y;
    logic [0:6] y_diff_d;

    gate_ref_model u_ref (
        .vec_i (vec_q),
        .exp_o (exp_y)
    );

    // Per-bit mismatch of the current vector; only consumed in SAMPLE.
    always_comb begin
        y_diff_d = gate_y ^ exp_y;
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= 2'd0;
            hold_q       <= 4'd0;
            gate_a_q     <= 1'b0;
            gate_b_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_mask_q   <= '0;
            fail_vec_q   <= 4'd0;
            fail_count_q <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_DRIVE;
                        vec_q        <= 2'd0;
                        hold_q       <= 4'd0;
                        gate_a_q     <= 1'b0;
                        gate_b_q     <= 1'b0;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        err_mask_q   <= '0;
                        fail_vec_q   <= 4'd0;
                        fail_count_q <= 3'd0;
                    end
                end
                ST_DRIVE: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_q  <= 4'd0;
                        state_q <= ST_SAMPLE;
                    end else begin
                        hold_q <= hold_q + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    err_mask_q <= err_mask_q | y_diff_d;
                    if (|y_diff_d) begin
                        fail_vec_q[vec_q] <= 1'b1;
                        fail_count_q      <= fail_count_q + 3'd1;
                    end
                    if (vec_q == 2'd3) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                    end else begin
                        vec_q                <= vec_q + 2'd1;
                        {gate_a_q, gate_b_q} <= vec_q + 2'd1;
                        state_q              <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    // fail_vec_q already contains the last vector's result.
                    done_q  <= 1'b1;
                    pass_q  <= (fail_vec_q == 4'd0);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gate_a     = gate_a_q;
    assign gate_b     = gate_b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_mask   = err_mask_q;
    assign fail_vec   = fail_vec_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: a behavioural gate block with
// stuck-at injection feeds the sequencer; a second instance runs with
// HOLD_CYCLES=1 and start held high.
module tb_gate_test_sequencer;

    logic clk;
    logic rst_n;

    // Instance with default HOLD_CYCLES=2
    logic       start;
    logic       gate_a, gate_b;
    logic [0:6] gate_y;
    logic       busy, done, pass;
    logic [0:6] err_mask;
    logic [3:0] fail_vec;
    logic [2:0] fail_count;
    logic [0:6] force0, force1;

    // Instance with HOLD_CYCLES=1
    logic       start1;
    logic       gate_a1, gate_b1;
    logic [0:6] gate_y1;
    logic       busy1, done1, pass1;
    logic [0:6] err_mask1;
    logic [3:0] fail_vec1;
    logic [2:0] fail_count1;
    logic [0:6] force1_b;

    int n_checks;
    int n_errors;

    gate_test_sequencer #(.HOLD_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
        .busy(busy), .done(done), .pass(pass),
        .err_mask(err_mask), .fail_vec(fail_vec), .fail_count(fail_count)
    );

    gate_test_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .gate_a(gate_a1), .gate_b(gate_b1), .gate_y(gate_y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_mask(err_mask1), .fail_vec(fail_vec1), .fail_count(fail_count1)
    );

    // Clock and reset-level signals
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate block: AND, OR, NOT A, NAND, NOR, XOR, XNOR
    function automatic logic [0:6] gate_fn(input logic a, input logic b);
        return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    assign gate_y  = (gate_fn(gate_a, gate_b) & ~force0) | force1;
    assign gate_y1 = gate_fn(gate_a1, gate_b1) | force1_b;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " pass"}, 32'(pass), 0);
        check({tag, " err_mask"}, 32'(err_mask), 0);
        check({tag, " fail_vec"}, 32'(fail_vec), 0);
        check({tag, " fail_count"}, 32'(fail_count), 0);
        check({tag, " gate_ab"}, 32'({gate_a, gate_b}), 0);
    endtask

    // One full run on the HOLD_CYCLES=2 instance with expected results.
    task automatic run_check(input string tag, input logic [0:6] f0, input logic [0:6] f1,
                             input bit repulse, input logic ep, input logic [0:6] ee,
                             input logic [3:0] efv, input logic [2:0] efc);
        int c;
        int extra_done;
        bit seen;
        force0 = f0;
        force1 = f1;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, " busy@start"}, 32'(busy), 1);
        check({tag, " err_mask cleared"}, 32'(err_mask), 0);
        check({tag, " fail_count cleared"}, 32'(fail_count), 0);
        check({tag, " fail_vec cleared"}, 32'(fail_vec), 0);
        check({tag, " pass cleared"}, 32'(pass), 0);
        c = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            if (repulse && c == 5) start = 1'b1;
            step();
            start = 1'b0;
            c++;
            if (c % 3 == 1 && c < 12)
                check({tag, " vector order"}, 32'({gate_a, gate_b}), 32'(c / 3));
            if (done) seen = 1'b1;
        end
        check({tag, " done latency"}, 32'(c), 13);
        check({tag, " pass"}, 32'(pass), 32'(ep));
        check({tag, " err_mask"}, 32'(err_mask), 32'(ee));
        check({tag, " fail_vec"}, 32'(fail_vec), 32'(efv));
        check({tag, " fail_count"}, 32'(fail_count), 32'(efc));
        step();
        check({tag, " done one cycle"}, 32'(done), 0);
        check({tag, " busy idle"}, 32'(busy), 0);
        check({tag, " pass held"}, 32'(pass), 32'(ep));
        check({tag, " fail_vec held"}, 32'(fail_vec), 32'(efv));
        if (repulse) begin
            extra_done = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (done) extra_done++;
            end
            check({tag, " no queued run"}, 32'(extra_done), 0);
            check({tag, " idle after repulse"}, 32'(busy), 0);
        end
        force0 = '0;
        force1 = '0;
    endtask

    // Directed sequence
    initial begin
        int c;
        int ndone;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        start1   = 1'b0;
        force0   = '0;
        force1   = '0;
        force1_b = '0;
        step();
        step();
        check_reset_outputs("reset");
        check("reset dut1 fail_vec", 32'(fail_vec1), 0);
        rst_n = 1'b1;
        step();

        // Fault-free run
        run_check("clean", '0, '0, 1'b0, 1'b1, 7'b0000000, 4'b0000, 3'd0);
        // NOR stuck at 0: only vec 0 expects NOR=1
        run_check("nor_sa0", 7'b0000100, '0, 1'b0, 1'b0, 7'b0000100, 4'b0001, 3'd1);
        // XOR stuck at 1: vec 0 and vec 3 expect XOR=0
        run_check("xor_sa1", '0, 7'b0000010, 1'b0, 1'b0, 7'b0000010, 4'b1001, 3'd2);
        // start pulsed again mid-run must be ignored
        run_check("repulse", '0, '0, 1'b1, 1'b1, 7'b0000000, 4'b0000, 3'd0);

        // Reset during vec=2 DRIVE, with a fault so results are non-zero first
        force1 = 7'b0000010;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("midrun gate_a before reset", 32'(gate_a), 1);
        check("midrun fail_vec before reset", 32'(fail_vec), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        force1 = '0;
        check_reset_outputs("midrun reset");
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) ndone++;
        end
        check("midrun no done", 32'(ndone), 0);
        run_check("after_reset", '0, '0, 1'b0, 1'b1, 7'b0000000, 4'b0000, 3'd0);

        // HOLD_CYCLES=1 with start held high: done every 10 cycles
        start1 = 1'b1;
        step();
        c = 0;
        ndone = 0;
        while (c < 33) begin
            step();
            c++;
            if (done1) begin
                ndone++;
                check("hold1 done period", 32'(c % 10), 9);
                if (c == 9) begin
                    check("hold1 run1 pass", 32'(pass1), 1);
                    check("hold1 run1 fail_vec", 32'(fail_vec1), 0);
                    force1_b = 7'b1000000;
                end else if (c == 19) begin
                    check("hold1 run2 pass", 32'(pass1), 0);
                    check("hold1 run2 fail_vec", 32'(fail_vec1), 32'b0111);
                    check("hold1 run2 fail_count", 32'(fail_count1), 3);
                    check("hold1 run2 err_mask", 32'(err_mask1), 32'(7'b1000000));
                    force1_b = '0;
                end else if (c == 29) begin
                    check("hold1 run3 pass", 32'(pass1), 1);
                    check("hold1 run3 fail_vec", 32'(fail_vec1), 0);
                    check("hold1 run3 err_mask", 32'(err_mask1), 0);
                end
            end
        end
        check("hold1 done count", 32'(ndone), 3);
        start1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2: DRIVE cycles per input vector before sampling; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-005 SHALL have port gate_a, output, 1, operand A to the gate block.
REQ-006 SHALL have port gate_b, output, 1, operand B to the gate block.
REQ-007 SHALL have port gate_y, input, [0:6], gate results: 0 AND, 1 OR, 2 NOT A, 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
REQ-008 SHALL have port busy, output, 1, high in DRIVE and SAMPLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse at end of run.
REQ-010 SHALL have port pass, output, 1, run result; valid from done until next start.
REQ-011 SHALL have port err_mask, output, [0:6], sticky OR of per-bit mismatches over the run.
REQ-012 SHALL have port fail_vec, output, [3:0], bit k set when vector k mismatched.
REQ-013 SHALL have port fail_count, output, [2:0], number of mismatching vectors (0..4).

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE: start=1 -> DRIVE with vec=0; err_mask, fail_vec, fail_count and pass clear in the same edge.
REQ-016 Vector order SHALL be vec 0..3 = {gate_a,gate_b} 00, 01, 10, 11; outputs registered, stable for the whole DRIVE+SAMPLE window.
REQ-017 DRIVE SHALL last exactly HOLD_CYCLES cycles (hold counter), then -> SAMPLE.
REQ-018 SAMPLE (1 cycle) SHALL compare gate_y with the expected truth-table value for vec; mismatch bits OR into err_mask; any mismatch sets fail_vec[vec] and increments fail_count.
REQ-019 SAMPLE SHALL go to DRIVE with vec+1 if vec<3, else to DONE.
REQ-020 DONE SHALL assert done for one cycle, set pass = (fail_vec==0 after the final sample), then -> IDLE.
REQ-021 done SHALL assert exactly 4*(HOLD_CYCLES+1)+1 cycles after the edge at which start was sampled (13 for default).
REQ-022 start SHALL be ignored in DRIVE, SAMPLE and DONE; no queuing.
REQ-023 start held high continuously SHALL begin a new run on the first IDLE cycle after DONE.
REQ-024 gate_y SHALL be ignored outside SAMPLE.
REQ-025 Results (pass, err_mask, fail_vec, fail_count) SHALL hold in IDLE until the next accepted start.

Reset
REQ-026 rst_n=0 at a clk edge SHALL force IDLE, vec=0, hold counter 0, gate_a=gate_b=0, busy=0, done=0, pass=0, err_mask=0, fail_vec=0, fail_count=0.
REQ-027 Reset mid-run SHALL abort with no done pulse; the next start after release SHALL run normally.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, gate_y bit-index constants and the 4x7 expected truth table.
REQ-029 Expected-value lookup SHALL be one combinational sub-module, gate_ref_model (vec in, expected [0:6] out).

Verification
REQ-030 Correct gate block, HOLD_CYCLES=2, start pulse -> done 13 cycles later; pass=1, err_mask=0, fail_vec=0000, fail_count=0.
REQ-031 gate_y[4] (NOR) stuck at 0 -> pass=0, err_mask bit4 only, fail_vec=0001, fail_count=1.
REQ-032 gate_y[5] (XOR) stuck at 1 -> pass=0, err_mask bit5 only, fail_vec=1001, fail_count=2.
REQ-033 start pulsed again during cycle 5 of a run -> ignored; exactly one done, at the original cycle 13.
REQ-034 rst_n low for 1 cycle during the vec=2 DRIVE -> all outputs at reset values, no done; a following start gives a full 13-cycle pass run.
REQ-035 HOLD_CYCLES=1, start held high -> done every 10 cycles, results updated each run.
